// File: rtl/interp2_upsampler.sv
// Linear-interpolating upsampler: each input sample yields 2**LOG2_L outputs
// ramping from the previous sample to the new one. Define INTERP_ROUND_EN for rounding.
module interp2_upsampler #(
  parameter int DATA_W = 8,
  parameter int LOG2_L = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_ce,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     o_ready,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     o_ce,
  output logic                     o_overrun
);

  localparam int AW = DATA_W + LOG2_L + 1;
  localparam int DW = DATA_W + 1;
  localparam int KW = LOG2_L + 1;
  localparam logic [KW-1:0] K_LAST = KW'(2 ** LOG2_L);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                    state_q;
  logic signed [DATA_W-1:0]  cur_q;
  logic signed [DATA_W-1:0]  prev_q;
  logic signed [DW-1:0]      diff_q;
  logic signed [AW-1:0]      acc_q;
  logic        [KW-1:0]      k_q;
  logic signed [DATA_W-1:0]  data_out_q;
  logic                      o_ce_q;
  logic                      o_overrun_q;
  logic                      o_ready_q;

  logic                      accept;
  logic                      last;
  logic signed [DATA_W-1:0]  base;
  logic signed [DW-1:0]      diff_d;
  logic signed [AW-1:0]      acc_d;
  logic signed [AW-1:0]      sum;
  logic signed [AW-1:0]      rnd;
  logic signed [AW-1:0]      shifted;
  logic signed [DATA_W-1:0]  out_d;
  logic        [KW-1:0]      k_inc;

`ifdef INTERP_ROUND_EN
  localparam logic signed [AW-1:0] HALF = AW'(1) << (LOG2_L - 1);
`endif

  assign accept = i_ce && o_ready_q;
  assign last   = (state_q == RUN) && (k_q == K_LAST);

  // A new segment starts from the last emitted endpoint (cur) when chained,
  // otherwise from the stored previous sample.
  always_comb begin
    base   = (state_q == RUN) ? cur_q : prev_q;
    diff_d = {data_in[DATA_W-1], data_in} - {base[DATA_W-1], base};
    acc_d  = {base[DATA_W-1], base, {LOG2_L{1'b0}}};
  end

  // Next ramp point in the scaled domain and its shifted-down output value.
  always_comb begin
    sum = acc_q + {{LOG2_L{diff_q[DW-1]}}, diff_q};
`ifdef INTERP_ROUND_EN
    rnd = sum + HALF;
`else
    rnd = sum;
`endif
    shifted = rnd >>> LOG2_L;
    out_d   = shifted[DATA_W-1:0];
    k_inc   = k_q + K_ONE;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      prev_q      <= '0;
      diff_q      <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      data_out_q  <= '0;
      o_ce_q      <= 1'b0;
      o_overrun_q <= 1'b0;
      o_ready_q   <= 1'b1;
    end else begin
      o_ce_q      <= 1'b0;
      o_overrun_q <= i_ce && !o_ready_q;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cur_q     <= data_in;
            diff_q    <= diff_d;
            acc_q     <= acc_d;
            k_q       <= K_ONE;
            o_ready_q <= (K_ONE == K_LAST);
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q      <= sum;
          data_out_q <= out_d;
          o_ce_q     <= 1'b1;
          if (last) begin
            prev_q <= cur_q;
            if (accept) begin
              cur_q     <= data_in;
              diff_q    <= diff_d;
              acc_q     <= acc_d;
              k_q       <= K_ONE;
              o_ready_q <= (K_ONE == K_LAST);
            end else begin
              k_q       <= '0;
              o_ready_q <= 1'b1;
              state_q   <= IDLE;
            end
          end else begin
            k_q       <= k_inc;
            o_ready_q <= (k_inc == K_LAST);
          end
        end
        default: begin
          state_q   <= IDLE;
          o_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready   = o_ready_q;
  assign data_out  = data_out_q;
  assign o_ce      = o_ce_q;
  assign o_overrun = o_overrun_q;

endmodule

// File: tb/tb_interp2_upsampler.sv
// Directed bench for interp2_upsampler: L=2 main instance, L=4 side instance.
module tb_interp2_upsampler;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_ce;
  logic signed [7:0] data_in;
  logic              o_ready;
  logic signed [7:0] data_out;
  logic              o_ce;
  logic              o_overrun;

  logic              i_ce2;
  logic signed [7:0] data_in2;
  logic              o_ready2;
  logic signed [7:0] data_out2;
  logic              o_ce2;
  logic              o_overrun2;

  int checks = 0;
  int errors = 0;

  int exp_oce[7] = '{0, 1, 1, 1, 1, 1, 1};
  int exp_out[7] = '{0, 64, 1, 2, 3, 4, 5};
  int exp_ovr[7] = '{0, 1, 0, 1, 0, 1, 0};
  int exp_rdy[7] = '{0, 1, 0, 1, 0, 1, 1};

  interp2_upsampler #(.DATA_W(8), .LOG2_L(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_ce      (i_ce),
    .data_in   (data_in),
    .o_ready   (o_ready),
    .data_out  (data_out),
    .o_ce      (o_ce),
    .o_overrun (o_overrun)
  );

  interp2_upsampler #(.DATA_W(8), .LOG2_L(2)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .i_ce      (i_ce2),
    .data_in   (data_in2),
    .o_ready   (o_ready2),
    .data_out  (data_out2),
    .o_ce      (o_ce2),
    .o_overrun (o_overrun2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic burst2(input string tag,
                        input logic signed [7:0] d,
                        input int e1,
                        input int e2);
    data_in = d;
    i_ce    = 1'b1;
    tick();
    i_ce = 1'b0;
    check({tag, "_rdy0"}, 32'(o_ready), 0);
    check({tag, "_oce0"}, 32'(o_ce), 0);
    tick();
    check({tag, "_oce1"}, 32'(o_ce), 1);
    check({tag, "_out1"}, 32'(data_out), e1);
    check({tag, "_rdy1"}, 32'(o_ready), 1);
    tick();
    check({tag, "_oce2"}, 32'(o_ce), 1);
    check({tag, "_out2"}, 32'(data_out), e2);
    tick();
    check({tag, "_oce3"}, 32'(o_ce), 0);
    check({tag, "_ovr"}, 32'(o_overrun), 0);
  endtask

  initial begin
    int round_exp;
`ifdef INTERP_ROUND_EN
    round_exp = 0;
`else
    round_exp = -1;
`endif
    reset    = 1'b1;
    i_ce     = 1'b0;
    data_in  = '0;
    i_ce2    = 1'b0;
    data_in2 = '0;
    tick();
    tick();
    check("rst_out", 32'(data_out), 0);
    check("rst_oce", 32'(o_ce), 0);
    check("rst_ovr", 32'(o_overrun), 0);
    check("rst_rdy", 32'(o_ready), 1);
    check("rst_rdy4", 32'(o_ready2), 1);
    reset = 1'b0;
    tick();

    burst2("s10", 8'sd10, 5, 10);
    burst2("sm6", -8'sd6, 2, -6);
    burst2("sm128", -8'sd128, -67, -128);
    burst2("s127", 8'sd127, round_exp, 127);

    for (int j = 0; j < 7; j++) begin
      if (j < 6) begin
        i_ce    = 1'b1;
        data_in = 8'(j + 1);
      end else begin
        i_ce = 1'b0;
      end
      tick();
      check($sformatf("cont_oce%0d", j), 32'(o_ce), exp_oce[j]);
      check($sformatf("cont_ovr%0d", j), 32'(o_overrun), exp_ovr[j]);
      check($sformatf("cont_rdy%0d", j), 32'(o_ready), exp_rdy[j]);
      if (j > 0)
        check($sformatf("cont_out%0d", j), 32'(data_out), exp_out[j]);
    end
    tick();
    check("cont_end_oce", 32'(o_ce), 0);

    data_in2 = 8'sd8;
    i_ce2    = 1'b1;
    tick();
    i_ce2 = 1'b0;
    check("l4_rdy0", 32'(o_ready2), 0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      check($sformatf("l4_oce%0d", j), 32'(o_ce2), 1);
      check($sformatf("l4_out%0d", j), 32'(data_out2), 2 * j);
    end
    check("l4_rdy_end", 32'(o_ready2), 1);
    tick();
    check("l4_oce_end", 32'(o_ce2), 0);

    data_in = 8'sd100;
    i_ce    = 1'b1;
    tick();
    i_ce = 1'b0;
    tick();
    check("mid_oce", 32'(o_ce), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_oce", 32'(o_ce), 0);
    check("mid_rst_out", 32'(data_out), 0);
    check("mid_rst_rdy", 32'(o_ready), 1);
    tick();
    check("mid_idle_oce", 32'(o_ce), 0);
    burst2("s4", 8'sd4, 2, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
